dca_step_dispatch_multi: RTL and testbench

//  Parametrised step-instruction dispatcher for the DCA matrix core. Buffers blocked-step

---
 rtl/dca_step_dispatch_multi.sv | 172 +++++++++++++++++
 tb/tb_dca_step_dispatch_multi.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dca_step_dispatch_multi.sv
// Step-instruction dispatcher: buffers instructions, waits for their load operands,
// issues them to the step engine, then releases loads and optionally commits the store.
module dca_step_dispatch_multi #(
  parameter int BW_INST     = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int NUM_LOAD_CH = 3
) (
  input  logic                              clk,
  input  logic                              rstnn,
  input  logic                              clear,
  input  logic                              enable,
  output logic                              busy,
  output logic                              inst_wready,
  input  logic                              inst_wrequest,
  input  logic [BW_INST-1:0]                inst_wdata,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   num_pending,
  input  logic [NUM_LOAD_CH-1:0]            loadreg_rready,
  output logic [NUM_LOAD_CH-1:0]            loadreg_rrequest,
  output logic                              step_valid,
  input  logic                              step_ready,
  output logic [BW_INST-1:0]                step_inst,
  input  logic                              step_done,
  input  logic                              storereg_wready,
  output logic                              storereg_wrequest
);

  localparam int PtrW = $clog2(FIFO_DEPTH);
  localparam int CntW = $clog2(FIFO_DEPTH+1);
  localparam logic [PtrW-1:0] PtrOne = 1;
  localparam logic [CntW-1:0] CntOne = 1;
  localparam logic [CntW-1:0] CntFull = FIFO_DEPTH[CntW-1:0];

  typedef enum logic [2:0] {
    StIdle,
    StWaitOpnd,
    StIssue,
    StExec,
    StWaitStore
  } state_e;

  state_e                  state_q;
  logic [BW_INST-1:0]      curInst_q;
  logic                    stepValid_q;
  logic [NUM_LOAD_CH-1:0]  rrequest_q;
  logic                    wrequest_q;

  logic [BW_INST-1:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]         wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]         rdPtr_q, rdPtr_d;
  logic [CntW-1:0]         count_q, count_d;

  logic                    fifoFull;
  logic                    fifoEmpty;
  logic                    push;
  logic                    pop;
  logic [NUM_LOAD_CH-1:0]  curMask;
  logic                    curStore;

  assign fifoFull  = (count_q == CntFull);
  assign fifoEmpty = (count_q == '0);
  assign curMask   = curInst_q[NUM_LOAD_CH-1:0];
  assign curStore  = curInst_q[NUM_LOAD_CH];

  // inst_wready already excludes full, so a pop in the same cycle never frees a slot early
  assign inst_wready = enable & ~fifoFull;
  assign push        = inst_wrequest & inst_wready & ~clear;
  assign pop         = enable & ~clear & (state_q == StIdle) & ~fifoEmpty;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = wrPtr_q + PtrOne;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PtrOne;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (clear) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= inst_wdata;
    end
  end

  // Pulse registers are cleared every cycle so each release/commit lasts exactly one cycle
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q     <= StIdle;
      curInst_q   <= '0;
      stepValid_q <= 1'b0;
      rrequest_q  <= '0;
      wrequest_q  <= 1'b0;
    end else if (clear) begin
      state_q     <= StIdle;
      curInst_q   <= '0;
      stepValid_q <= 1'b0;
      rrequest_q  <= '0;
      wrequest_q  <= 1'b0;
    end else begin
      rrequest_q <= '0;
      wrequest_q <= 1'b0;
      if (enable) begin
        case (state_q)
          StIdle: begin
            if (!fifoEmpty) begin
              curInst_q <= mem_q[rdPtr_q];
              state_q   <= StWaitOpnd;
            end
          end
          StWaitOpnd: begin
            if ((loadreg_rready & curMask) == curMask) begin
              stepValid_q <= 1'b1;
              state_q     <= StIssue;
            end
          end
          StIssue: begin
            if (step_ready) begin
              stepValid_q <= 1'b0;
              state_q     <= StExec;
            end
          end
          StExec: begin
            if (step_done) begin
              rrequest_q <= curMask;
              state_q    <= curStore ? StWaitStore : StIdle;
            end
          end
          StWaitStore: begin
            if (storereg_wready) begin
              wrequest_q <= 1'b1;
              state_q    <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign busy              = (state_q != StIdle) | ~fifoEmpty;
  assign num_pending       = count_q;
  assign step_inst         = curInst_q;
  assign step_valid        = stepValid_q & enable;
  assign loadreg_rrequest  = rrequest_q & {NUM_LOAD_CH{enable}};
  assign storereg_wrequest = wrequest_q & enable;

  a_noPushWhenFull: assert property (@(posedge clk) disable iff (!rstnn) !(push && fifoFull));

endmodule

// File: tb/tb_dca_step_dispatch_multi.sv
// Directed bench for dca_step_dispatch_multi: one task per scenario with inline checks
// against hand-computed cycle timelines (inputs driven and outputs sampled on negedge).
module tb_dca_step_dispatch_multi;

  logic        clk = 1'b0;
  logic        rstnn;
  logic        clear;
  logic        enable;
  logic        busy;
  logic        inst_wready;
  logic        inst_wrequest;
  logic [15:0] inst_wdata;
  logic [2:0]  num_pending;
  logic [2:0]  loadreg_rready;
  logic [2:0]  loadreg_rrequest;
  logic        step_valid;
  logic        step_ready;
  logic [15:0] step_inst;
  logic        step_done;
  logic        storereg_wready;
  logic        storereg_wrequest;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dca_step_dispatch_multi #(
    .BW_INST(16),
    .FIFO_DEPTH(4),
    .NUM_LOAD_CH(3)
  ) dut (
    .clk(clk),
    .rstnn(rstnn),
    .clear(clear),
    .enable(enable),
    .busy(busy),
    .inst_wready(inst_wready),
    .inst_wrequest(inst_wrequest),
    .inst_wdata(inst_wdata),
    .num_pending(num_pending),
    .loadreg_rready(loadreg_rready),
    .loadreg_rrequest(loadreg_rrequest),
    .step_valid(step_valid),
    .step_ready(step_ready),
    .step_inst(step_inst),
    .step_done(step_done),
    .storereg_wready(storereg_wready),
    .storereg_wrequest(storereg_wrequest)
  );

  // Waits up to limit negedges for step_valid; caller judges the outcome
  task automatic waitValid(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (step_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstnn = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (inst_wready !== 1'b1) begin bad++; $display("[TB] FAIL reset_wready_in_reset: got %b want 1", inst_wready); end
    rstnn = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    total++; if (inst_wready !== 1'b1) begin bad++; $display("[TB] FAIL reset_wready: got %b want 1", inst_wready); end
    total++; if (num_pending !== 3'd0) begin bad++; $display("[TB] FAIL reset_pending: got %0d want 0", num_pending); end
    total++; if (step_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", step_valid); end
    total++; if (loadreg_rrequest !== 3'b000) begin bad++; $display("[TB] FAIL reset_rrequest: got %b want 000", loadreg_rrequest); end
    total++; if (storereg_wrequest !== 1'b0) begin bad++; $display("[TB] FAIL reset_wrequest: got %b want 0", storereg_wrequest); end
    total++; if (step_inst !== 16'h0000) begin bad++; $display("[TB] FAIL reset_inst: got %h want 0000", step_inst); end
    enable = 1'b0;
    #1;
    total++; if (inst_wready !== 1'b0) begin bad++; $display("[TB] FAIL wready_disabled: got %b want 0", inst_wready); end
    enable = 1'b1;
  endtask

  task automatic test_single_op();
    loadreg_rready = 3'b011;
    step_ready = 1'b1;
    inst_wdata = 16'h0013;
    inst_wrequest = 1'b1;
    @(negedge clk);
    inst_wrequest = 1'b0;
    total++; if (num_pending !== 3'd1) begin bad++; $display("[TB] FAIL single_pending: got %0d want 1", num_pending); end
    total++; if (step_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_valid_c1: got %b want 0", step_valid); end
    @(negedge clk);
    total++; if (step_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_valid_c2: got %b want 0", step_valid); end
    @(negedge clk);
    total++; if (step_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid_c3: got %b want 1", step_valid); end
    total++; if (step_inst !== 16'h0013) begin bad++; $display("[TB] FAIL single_inst: got %h want 0013", step_inst); end
    @(negedge clk);
    total++; if (step_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_valid_exec: got %b want 0", step_valid); end
    step_done = 1'b1;
    @(negedge clk);
    step_done = 1'b0;
    total++; if (loadreg_rrequest !== 3'b011) begin bad++; $display("[TB] FAIL single_rrequest: got %b want 011", loadreg_rrequest); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy: got %b want 0", busy); end
    @(negedge clk);
    total++; if (loadreg_rrequest !== 3'b000) begin bad++; $display("[TB] FAIL single_rrequest_end: got %b want 000", loadreg_rrequest); end
  endtask

  task automatic test_operand_stall_store();
    bit sawValid;
    int wCount;
    sawValid = 1'b0;
    wCount = 0;
    loadreg_rready = 3'b001;
    step_ready = 1'b1;
    storereg_wready = 1'b0;
    inst_wdata = 16'h000D;
    inst_wrequest = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      inst_wrequest = 1'b0;
      if (step_valid) sawValid = 1'b1;
    end
    total++; if (sawValid !== 1'b0) begin bad++; $display("[TB] FAIL stall_no_valid: got %b want 0", sawValid); end
    loadreg_rready = 3'b101;
    @(negedge clk);
    total++; if (step_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_issue: got %b want 1", step_valid); end
    total++; if (step_inst !== 16'h000D) begin bad++; $display("[TB] FAIL stall_inst: got %h want 000d", step_inst); end
    @(negedge clk);
    step_done = 1'b1;
    @(negedge clk);
    step_done = 1'b0;
    total++; if (loadreg_rrequest !== 3'b101) begin bad++; $display("[TB] FAIL stall_rrequest: got %b want 101", loadreg_rrequest); end
    if (storereg_wrequest) wCount++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (storereg_wrequest) wCount++;
    end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL store_wait_busy: got %b want 1", busy); end
    total++; if (wCount !== 0) begin bad++; $display("[TB] FAIL store_early: got %0d pulses want 0", wCount); end
    storereg_wready = 1'b1;
    @(negedge clk);
    total++; if (storereg_wrequest !== 1'b1) begin bad++; $display("[TB] FAIL store_pulse: got %b want 1", storereg_wrequest); end
    if (storereg_wrequest) wCount++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (storereg_wrequest) wCount++;
    end
    total++; if (wCount !== 1) begin bad++; $display("[TB] FAIL store_pulse_count: got %0d want 1", wCount); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL store_busy_end: got %b want 0", busy); end
    storereg_wready = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic [15:0] got [6];
    logic [15:0] expInst;
    int issued;
    bit doneNext;
    issued = 0;
    doneNext = 1'b0;
    for (int k = 0; k < 6; k++) got[k] = 16'h0000;
    loadreg_rready = 3'b111;
    step_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      inst_wdata = 16'hA000 + 16'(k * 16'h0100);
      inst_wrequest = 1'b1;
      @(negedge clk);
    end
    inst_wrequest = 1'b0;
    total++; if (num_pending !== 3'd4) begin bad++; $display("[TB] FAIL full_pending: got %0d want 4", num_pending); end
    total++; if (inst_wready !== 1'b0) begin bad++; $display("[TB] FAIL full_wready: got %b want 0", inst_wready); end
    total++; if (step_valid !== 1'b1) begin bad++; $display("[TB] FAIL full_head_valid: got %b want 1", step_valid); end
    total++; if (step_inst !== 16'hA000) begin bad++; $display("[TB] FAIL full_head_inst: got %h want a000", step_inst); end
    step_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (step_valid && step_ready) begin
        if (issued < 6) got[issued] = step_inst;
        issued++;
        doneNext = 1'b1;
      end
      @(negedge clk);
      step_done = 1'b0;
      if (doneNext) begin
        step_done = 1'b1;
        doneNext = 1'b0;
      end
    end
    step_done = 1'b0;
    total++; if (issued !== 5) begin bad++; $display("[TB] FAIL full_issue_count: got %0d want 5", issued); end
    for (int k = 0; k < 5; k++) begin
      expInst = 16'hA000 + 16'(k * 16'h0100);
      total++; if (got[k] !== expInst) begin bad++; $display("[TB] FAIL full_order_%0d: got %h want %h", k, got[k], expInst); end
    end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL full_drain_busy: got %b want 0", busy); end
    total++; if (num_pending !== 3'd0) begin bad++; $display("[TB] FAIL full_drain_pending: got %0d want 0", num_pending); end
  endtask

  task automatic test_back_to_back();
    loadreg_rready = 3'b111;
    step_ready = 1'b1;
    inst_wdata = 16'h0040;
    inst_wrequest = 1'b1;
    @(negedge clk);
    inst_wdata = 16'h0050;
    @(negedge clk);
    inst_wrequest = 1'b0;
    total++; if (step_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_valid_c2: got %b want 0", step_valid); end
    @(negedge clk);
    total++; if (step_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_valid_first: got %b want 1", step_valid); end
    total++; if (step_inst !== 16'h0040) begin bad++; $display("[TB] FAIL b2b_inst_first: got %h want 0040", step_inst); end
    @(negedge clk);
    step_done = 1'b1;
    @(negedge clk);
    step_done = 1'b0;
    total++; if (step_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_gap1: got %b want 0", step_valid); end
    @(negedge clk);
    total++; if (step_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_gap2: got %b want 0", step_valid); end
    @(negedge clk);
    total++; if (step_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_valid_second: got %b want 1", step_valid); end
    total++; if (step_inst !== 16'h0050) begin bad++; $display("[TB] FAIL b2b_inst_second: got %h want 0050", step_inst); end
    @(negedge clk);
    step_done = 1'b1;
    @(negedge clk);
    step_done = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_clear_exec();
    bit sawValid;
    bit ok;
    sawValid = 1'b0;
    loadreg_rready = 3'b111;
    step_ready = 1'b1;
    inst_wdata = 16'h001B;
    inst_wrequest = 1'b1;
    @(negedge clk);
    inst_wdata = 16'h0021;
    @(negedge clk);
    inst_wdata = 16'h0022;
    @(negedge clk);
    inst_wrequest = 1'b0;
    total++; if (step_valid !== 1'b1) begin bad++; $display("[TB] FAIL clr_issue: got %b want 1", step_valid); end
    @(negedge clk);
    total++; if (num_pending !== 3'd2) begin bad++; $display("[TB] FAIL clr_pending_before: got %0d want 2", num_pending); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL clr_busy_before: got %b want 1", busy); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL clr_busy_after: got %b want 0", busy); end
    total++; if (num_pending !== 3'd0) begin bad++; $display("[TB] FAIL clr_pending_after: got %0d want 0", num_pending); end
    step_done = 1'b1;
    @(negedge clk);
    step_done = 1'b0;
    total++; if (loadreg_rrequest !== 3'b000) begin bad++; $display("[TB] FAIL clr_late_done_rrequest: got %b want 000", loadreg_rrequest); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (step_valid) sawValid = 1'b1;
    end
    total++; if (sawValid !== 1'b0) begin bad++; $display("[TB] FAIL clr_no_issue: got %b want 0", sawValid); end
    inst_wdata = 16'h0003;
    inst_wrequest = 1'b1;
    @(negedge clk);
    inst_wrequest = 1'b0;
    waitValid(10, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL clr2_valid_timeout: got %b want 1", ok); end
    @(negedge clk);
    step_done = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    step_done = 1'b0;
    clear = 1'b0;
    total++; if (loadreg_rrequest !== 3'b000) begin bad++; $display("[TB] FAIL clr_with_done_rrequest: got %b want 000", loadreg_rrequest); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL clr_with_done_busy: got %b want 0", busy); end
  endtask

  task automatic test_enable_freeze();
    bit sawValid;
    bit ok;
    sawValid = 1'b0;
    loadreg_rready = 3'b111;
    step_ready = 1'b0;
    inst_wdata = 16'h0057;
    inst_wrequest = 1'b1;
    @(negedge clk);
    inst_wrequest = 1'b0;
    waitValid(10, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL frz_valid_timeout: got %b want 1", ok); end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (step_valid) sawValid = 1'b1;
    end
    total++; if (sawValid !== 1'b0) begin bad++; $display("[TB] FAIL frz_valid_forced: got %b want 0", sawValid); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL frz_busy: got %b want 1", busy); end
    total++; if (inst_wready !== 1'b0) begin bad++; $display("[TB] FAIL frz_wready: got %b want 0", inst_wready); end
    enable = 1'b1;
    #1;
    total++; if (step_valid !== 1'b1) begin bad++; $display("[TB] FAIL frz_valid_resume: got %b want 1", step_valid); end
    total++; if (step_inst !== 16'h0057) begin bad++; $display("[TB] FAIL frz_inst_resume: got %h want 0057", step_inst); end
    step_ready = 1'b1;
    @(negedge clk);
    total++; if (step_valid !== 1'b0) begin bad++; $display("[TB] FAIL frz_valid_exec: got %b want 0", step_valid); end
    step_done = 1'b1;
    @(negedge clk);
    step_done = 1'b0;
    total++; if (loadreg_rrequest !== 3'b111) begin bad++; $display("[TB] FAIL frz_rrequest: got %b want 111", loadreg_rrequest); end
    loadreg_rready = 3'b000;
    inst_wdata = 16'h0080;
    inst_wrequest = 1'b1;
    @(negedge clk);
    inst_wrequest = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (step_valid !== 1'b1) begin bad++; $display("[TB] FAIL mask0_valid: got %b want 1", step_valid); end
    total++; if (step_inst !== 16'h0080) begin bad++; $display("[TB] FAIL mask0_inst: got %h want 0080", step_inst); end
    @(negedge clk);
    step_done = 1'b1;
    @(negedge clk);
    step_done = 1'b0;
    total++; if (loadreg_rrequest !== 3'b000) begin bad++; $display("[TB] FAIL mask0_rrequest: got %b want 000", loadreg_rrequest); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mask0_busy: got %b want 0", busy); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstnn = 1'b0;
    clear = 1'b0;
    enable = 1'b0;
    inst_wrequest = 1'b0;
    inst_wdata = 16'h0000;
    loadreg_rready = 3'b000;
    step_ready = 1'b0;
    step_done = 1'b0;
    storereg_wready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_op();
    test_operand_stall_store();
    test_fifo_full();
    test_back_to_back();
    test_clear_exec();
    test_enable_freeze();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
